// File: rtl/wb_arbiter.sv
// Writeback arbiter: one-entry result buffer per requester, drained onto CDB_W result buses in round-robin order.
// Define WBARB_BYPASS_EN to let an empty requester's incoming result reach a bus in the same cycle.
package uarch_pkg;
   localparam int unsigned PIPE_WIDTH = 2;

   typedef struct packed {
      logic [5:0]  rob_idx;
      logic [31:0] data;
      logic        exc;
   } writeback_packet_t;
endpackage

module wb_arbiter
   import uarch_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 4,
   parameter  int unsigned CDB_W   = PIPE_WIDTH,
   localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                flush,
   input  logic [NUM_REQ-1:0]                  req_valid,
   input  writeback_packet_t [NUM_REQ-1:0]     req_packet,
   output logic [NUM_REQ-1:0]                  req_ready,
   output logic [CDB_W-1:0]                    cdb_valid,
   output writeback_packet_t [CDB_W-1:0]       cdb_ports,
   output logic [CDB_W-1:0][IDX_W-1:0]         cdb_src
);

   logic [NUM_REQ-1:0]              buf_valid_q, buf_valid_d;
   writeback_packet_t [NUM_REQ-1:0] buf_pkt_q, buf_pkt_d;
   logic [IDX_W-1:0]                rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0]              bypass;
   logic [NUM_REQ-1:0]              cand;
   logic [NUM_REQ-1:0]              grant;

   always_comb begin
      bypass = '0;
`ifdef WBARB_BYPASS_EN
      bypass = {NUM_REQ{rst_n & ~flush}} & ~buf_valid_q & req_valid;
`endif
      cand = buf_valid_q | bypass;
   end

   // Two passes over the requesters emulate a wrap-around scan starting at rr_ptr_q.
   always_comb begin
      int cnt;
      int last;
      grant     = '0;
      cdb_valid = '0;
      cdb_ports = '0;
      cdb_src   = '0;
      rr_ptr_d  = rr_ptr_q;
      cnt       = 0;
      last      = 0;
      if (!flush) begin
         for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (((pass == 0) == (i >= int'(rr_ptr_q))) && cand[i] && (cnt < int'(CDB_W))) begin
                  grant[i] = 1'b1;
                  for (int n = 0; n < CDB_W; n++) begin
                     if (n == cnt) begin
                        cdb_valid[n] = 1'b1;
                        cdb_ports[n] = buf_valid_q[i] ? buf_pkt_q[i] : req_packet[i];
                        cdb_src[n]   = IDX_W'(i);
                     end
                  end
                  cnt  = cnt + 1;
                  last = i;
               end
            end
         end
         if (cnt != 0) begin
            rr_ptr_d = IDX_W'((last + 1) % int'(NUM_REQ));
         end
      end
   end

   assign req_ready = {NUM_REQ{~flush}} & (~buf_valid_q | grant);

   always_comb begin
      buf_valid_d = buf_valid_q;
      buf_pkt_d   = buf_pkt_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (flush) begin
            buf_valid_d[i] = 1'b0;
         end else if (req_valid[i] && req_ready[i] && !(bypass[i] && grant[i])) begin
            buf_valid_d[i] = 1'b1;
            buf_pkt_d[i]   = req_packet[i];
         end else if (grant[i]) begin
            buf_valid_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_valid_q <= '0;
         buf_pkt_q   <= '0;
         rr_ptr_q    <= '0;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_pkt_q   <= buf_pkt_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of writeback requesters (0=alu0, 1=alu1, 2=mdu, 3=dmem).
REQ-002 Parameter CDB_W, default PIPE_WIDTH (uarch_pkg), number of CDB ports.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  pipeline flush; discards all buffered results.
REQ-006 req_valid  input  NUM_REQ  requester i presents a result.
REQ-007 req_packet  input  writeback_packet_t [NUM_REQ]  result payloads.
REQ-008 req_ready  output  NUM_REQ  requester i's result accepted this cycle when req_valid[i] && req_ready[i].
REQ-009 cdb_valid  output  CDB_W  CDB port k carries a result.
REQ-010 cdb_ports  output  writeback_packet_t [CDB_W]  broadcast payloads to ROB and execute.
REQ-011 cdb_src  output  CDB_W x clog2(NUM_REQ)  requester index driving port k.

Function
REQ-012 Each requester owns a one-entry holding buffer (buf_valid[i], buf_pkt[i]).
REQ-013 req_ready[i] = !flush && (!buf_valid[i] || grant[i]); no combinational path from req_valid to req_ready.
REQ-014 Accepted handshake loads buf[i] on the next edge; granted-and-reloaded same cycle keeps buf_valid[i]=1 with new payload.
REQ-015 Granted entry not reloaded clears buf_valid[i] on the next edge.
REQ-016 Arbitration: round-robin pointer rr_ptr (0..NUM_REQ-1); scan indices rr_ptr, rr_ptr+1, ... mod NUM_REQ; first CDB_W valid candidates granted.
REQ-017 n-th granted candidate drives port n (n=0 first); ports beyond grant count: cdb_valid=0, cdb_ports all-zero, cdb_src=0.
REQ-018 Port outputs are combinational from buffer state; base latency accept->CDB is exactly 1 cycle.
REQ-019 rr_ptr updates to (last granted index + 1) mod NUM_REQ when any grant occurs; unchanged otherwise.
REQ-020 A requester is never granted on two ports in one cycle; at most CDB_W grants per cycle.
REQ-021 Starvation bound: any buffered entry is granted within ceil(NUM_REQ/CDB_W) cycles.
REQ-022 flush cycle: cdb_valid all 0, req_ready all 0, no grants, rr_ptr unchanged; all buf_valid cleared on next edge.
REQ-023 flush overrides simultaneous accepts and grants.

Reset
REQ-024 rst_n low: buf_valid all 0, buf_pkt zero, rr_ptr=0, immediately (asynchronous).
REQ-025 During and after reset: cdb_valid=0, cdb_ports zero, cdb_src=0, req_ready all 1 (unless flush).
REQ-026 Reset mid-operation drops all buffered results with no CDB broadcast.

Configuration
REQ-027 Macro WBARB_BYPASS_EN selects same-cycle bypass.
REQ-028 Defined: requester with buf_valid[i]=0 and req_valid[i]=1 is a candidate that cycle with req_packet[i]; if granted it is broadcast combinationally (0-cycle latency) and not buffered; req_ready[i]=1.
REQ-029 Defined: buffered entries still use REQ-016 ordering; bypass candidates compete in same rr scan.
REQ-030 Undefined: no bypass; behaviour exactly REQ-012..REQ-023.

Verification
REQ-031 Reset, all four req_valid=1 one cycle (no bypass, CDB_W=2) -> next cycle ports grant 0,1 (rr_ptr->2); following cycle 2,3 (rr_ptr->0).
REQ-032 Requester 3 alone, continuous req_valid -> cdb_valid[0]=1, cdb_src[0]=3 every cycle after first, req_ready[3] held 1, back-to-back throughput 1/cycle.
REQ-033 rr_ptr=3, buffers 0,1,3 valid -> grants order 3 then 0 on ports 0,1; rr_ptr->1; entry 1 granted next cycle.
REQ-034 All buffers full, flush=1 -> cdb_valid=0 and req_ready=0 that cycle; next cycle all buf_valid=0, no broadcast.
REQ-035 rst_n asserted low mid-cycle with buffers full -> outputs zero immediately; after release rr_ptr=0, req_ready all 1.
REQ-036 WBARB_BYPASS_EN defined, idle, req_valid[2]=1 -> same cycle cdb_valid[0]=1, cdb_src[0]=2, payload equals req_packet[2]; no broadcast next cycle.
